// File: rtl/cluster_bus_txn_regulator.sv
// Per-port AXI AW/AR admission control: caps outstanding transactions per port
// and across all ports, sharing the global budget round-robin.

module cluster_bus_txn_regulator_port #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             grant_i,
  input  logic             retire_i,
  input  logic             mst_ready_i,
  output logic             idle_o,
  output logic             mst_valid_o,
  output logic             slv_ready_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             inc_o,
  output logic             dec_o,
  output logic             underflow_o
);
  typedef enum logic {IDLE, FWD} state_e;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_i) state_d = FWD;
      FWD:     if (mst_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // inc_o/dec_o report only real count movement so the engine total stays coherent
  always_comb begin
    inc_o       = grant_i & ~retire_i & (cnt_q != CNT_MAX);
    dec_o       = retire_i & ~grant_i & (cnt_q != '0);
    underflow_o = retire_i & (cnt_q == '0);
    cnt_d       = cnt_q;
    if (inc_o)      cnt_d = cnt_q + 1'b1;
    else if (dec_o) cnt_d = cnt_q - 1'b1;
  end

  assign idle_o      = (state_q == IDLE);
  assign mst_valid_o = (state_q == FWD);
  assign slv_ready_o = (state_q == FWD) & mst_ready_i;
  assign cnt_o       = cnt_q;
endmodule

module cluster_bus_txn_regulator_engine #(
  parameter int NB_PORTS      = 4,
  parameter int MAX_PORT_TXNS = 8,
  parameter int MAX_TOTAL     = 12,
  parameter int CNT_W         = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NB_PORTS-1:0]       slv_valid_i,
  output logic [NB_PORTS-1:0]       slv_ready_o,
  output logic [NB_PORTS-1:0]       mst_valid_o,
  input  logic [NB_PORTS-1:0]       mst_ready_i,
  input  logic [NB_PORTS-1:0]       retire_i,
  output logic [NB_PORTS*CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0]          total_o,
  output logic                      underflow_o
);
  localparam int PTR_W = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
  localparam int TOTAL_SAT = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] PORT_LIM  = CNT_W'(MAX_PORT_TXNS);
  localparam logic [CNT_W-1:0] TOTAL_LIM = CNT_W'(MAX_TOTAL);

  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [CNT_W-1:0]                total_q, total_d;
  logic [NB_PORTS-1:0]             idle, eligible, grant, inc, dec, uf;
  logic [NB_PORTS-1:0]             hi_mask, masked;
  logic [NB_PORTS-1:0][CNT_W-1:0]  cnt;
  int                              total_nxt;

  for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
    cluster_bus_txn_regulator_port #(.CNT_W(CNT_W)) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .grant_i     (grant[p]),
      .retire_i    (retire_i[p]),
      .mst_ready_i (mst_ready_i[p]),
      .idle_o      (idle[p]),
      .mst_valid_o (mst_valid_o[p]),
      .slv_ready_o (slv_ready_o[p]),
      .cnt_o       (cnt[p]),
      .inc_o       (inc[p]),
      .dec_o       (dec[p]),
      .underflow_o (uf[p])
    );
    assign eligible[p] = idle[p] & slv_valid_i[p] &
                         (~en_i | ((cnt[p] < PORT_LIM) & (total_q < TOTAL_LIM)));
    assign cnt_o[p*CNT_W +: CNT_W] = cnt[p];
  end

  // Lowest eligible index at or above the pointer wins, else lowest overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NB_PORTS; i++) hi_mask[i] = (i >= int'(ptr_q));
    masked = eligible & hi_mask;
    grant  = '0;
    ptr_d  = ptr_q;
    for (int i = NB_PORTS-1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        ptr_d    = (i == NB_PORTS-1) ? '0 : PTR_W'(i + 1);
      end
    end
    for (int i = NB_PORTS-1; i >= 0; i--) begin
      if (masked[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        ptr_d    = (i == NB_PORTS-1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  always_comb begin
    total_nxt = int'(total_q);
    for (int i = 0; i < NB_PORTS; i++) total_nxt = total_nxt + int'(inc[i]) - int'(dec[i]);
    if (total_nxt < 0)         total_nxt = 0;
    if (total_nxt > TOTAL_SAT) total_nxt = TOTAL_SAT;
    total_d = CNT_W'(total_nxt);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      total_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      total_q <= total_d;
    end
  end

  assign total_o     = total_q;
  assign underflow_o = |uf;
endmodule

module cluster_bus_txn_regulator #(
  parameter int NB_PORTS      = 4,
  parameter int MAX_PORT_TXNS = 8,
  parameter int MAX_RD_TOTAL  = 12,
  parameter int MAX_WR_TOTAL  = 12,
  localparam int MAX_RW  = (MAX_RD_TOTAL > MAX_WR_TOTAL) ? MAX_RD_TOTAL : MAX_WR_TOTAL,
  localparam int MAX_ALL = (MAX_PORT_TXNS > MAX_RW) ? MAX_PORT_TXNS : MAX_RW,
  localparam int CNT_W   = $clog2(MAX_ALL + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic [NB_PORTS-1:0]       slv_aw_valid_i,
  output logic [NB_PORTS-1:0]       slv_aw_ready_o,
  output logic [NB_PORTS-1:0]       mst_aw_valid_o,
  input  logic [NB_PORTS-1:0]       mst_aw_ready_i,
  input  logic [NB_PORTS-1:0]       slv_ar_valid_i,
  output logic [NB_PORTS-1:0]       slv_ar_ready_o,
  output logic [NB_PORTS-1:0]       mst_ar_valid_o,
  input  logic [NB_PORTS-1:0]       mst_ar_ready_i,
  input  logic [NB_PORTS-1:0]       b_valid_i,
  input  logic [NB_PORTS-1:0]       b_ready_i,
  input  logic [NB_PORTS-1:0]       r_valid_i,
  input  logic [NB_PORTS-1:0]       r_ready_i,
  input  logic [NB_PORTS-1:0]       r_last_i,
  output logic [NB_PORTS*CNT_W-1:0] rd_outstnd_o,
  output logic [NB_PORTS*CNT_W-1:0] wr_outstnd_o,
  output logic [CNT_W-1:0]          rd_total_o,
  output logic [CNT_W-1:0]          wr_total_o,
  output logic                      underflow_o
);
  logic underflow_q, underflow_d;
  logic uf_wr, uf_rd;

  cluster_bus_txn_regulator_engine #(
    .NB_PORTS(NB_PORTS), .MAX_PORT_TXNS(MAX_PORT_TXNS), .MAX_TOTAL(MAX_WR_TOTAL), .CNT_W(CNT_W)
  ) u_aw (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .slv_valid_i (slv_aw_valid_i),
    .slv_ready_o (slv_aw_ready_o),
    .mst_valid_o (mst_aw_valid_o),
    .mst_ready_i (mst_aw_ready_i),
    .retire_i    (b_valid_i & b_ready_i),
    .cnt_o       (wr_outstnd_o),
    .total_o     (wr_total_o),
    .underflow_o (uf_wr)
  );

  cluster_bus_txn_regulator_engine #(
    .NB_PORTS(NB_PORTS), .MAX_PORT_TXNS(MAX_PORT_TXNS), .MAX_TOTAL(MAX_RD_TOTAL), .CNT_W(CNT_W)
  ) u_ar (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .slv_valid_i (slv_ar_valid_i),
    .slv_ready_o (slv_ar_ready_o),
    .mst_valid_o (mst_ar_valid_o),
    .mst_ready_i (mst_ar_ready_i),
    .retire_i    (r_valid_i & r_ready_i & r_last_i),
    .cnt_o       (rd_outstnd_o),
    .total_o     (rd_total_o),
    .underflow_o (uf_rd)
  );

  assign underflow_d = underflow_q | uf_wr | uf_rd;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) underflow_q <= 1'b0;
    else         underflow_q <= underflow_d;
  end

  assign underflow_o = underflow_q;
endmodule

// File: tb/tb_cluster_bus_txn_regulator.sv
// Scoreboarded bench: expected grant order queued at stimulus time and popped on
// each crossbar-side handshake; counters checked directly at key points.
module tb_cluster_bus_txn_regulator;
  localparam int NB = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, en_i;
  logic [NB-1:0] slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic [NB-1:0] slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic [NB-1:0] b_valid, b_ready, r_valid, r_ready, r_last;
  logic [NB*CW-1:0] rd_outstnd, wr_outstnd;
  logic [CW-1:0] rd_total, wr_total;
  logic          underflow;
  logic [CW-1:0] rd_c [NB];
  logic [CW-1:0] wr_c [NB];

  int n_chk = 0;
  int n_err = 0;
  int ar_issued [NB];
  int ar_acc    [NB];
  int aw_issued [NB];
  int aw_acc    [NB];
  int ar_exp [$];
  int aw_exp [$];

  cluster_bus_txn_regulator #(
    .NB_PORTS(NB), .MAX_PORT_TXNS(8), .MAX_RD_TOTAL(12), .MAX_WR_TOTAL(12)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .en_i           (en_i),
    .slv_aw_valid_i (slv_aw_valid),
    .slv_aw_ready_o (slv_aw_ready),
    .mst_aw_valid_o (mst_aw_valid),
    .mst_aw_ready_i (mst_aw_ready),
    .slv_ar_valid_i (slv_ar_valid),
    .slv_ar_ready_o (slv_ar_ready),
    .mst_ar_valid_o (mst_ar_valid),
    .mst_ar_ready_i (mst_ar_ready),
    .b_valid_i      (b_valid),
    .b_ready_i      (b_ready),
    .r_valid_i      (r_valid),
    .r_ready_i      (r_ready),
    .r_last_i       (r_last),
    .rd_outstnd_o   (rd_outstnd),
    .wr_outstnd_o   (wr_outstnd),
    .rd_total_o     (rd_total),
    .wr_total_o     (wr_total),
    .underflow_o    (underflow)
  );

  for (genvar p = 0; p < NB; p++) begin : g_unpack
    assign rd_c[p] = rd_outstnd[p*CW +: CW];
    assign wr_c[p] = wr_outstnd[p*CW +: CW];
    a_ar_stable: assert property (@(posedge clk) disable iff (!rst_ni)
      slv_ar_valid[p] && !slv_ar_ready[p] |=> slv_ar_valid[p]);
    a_aw_stable: assert property (@(posedge clk) disable iff (!rst_ni)
      slv_aw_valid[p] && !slv_aw_ready[p] |=> slv_aw_valid[p]);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step(1);
    rst_ni = 1'b1;
  endtask

  // Initiator model: valid stays up while issued requests are not yet accepted.
  always_comb begin
    for (int p = 0; p < NB; p++) begin
      slv_ar_valid[p] = (ar_issued[p] != ar_acc[p]);
      slv_aw_valid[p] = (aw_issued[p] != aw_acc[p]);
    end
  end

  always @(posedge clk) begin
    for (int p = 0; p < NB; p++) begin
      if (!rst_ni) begin
        ar_acc[p] <= ar_issued[p];
        aw_acc[p] <= aw_issued[p];
      end else begin
        if (slv_ar_valid[p] && slv_ar_ready[p]) ar_acc[p] <= ar_acc[p] + 1;
        if (slv_aw_valid[p] && slv_aw_ready[p]) aw_acc[p] <= aw_acc[p] + 1;
      end
    end
  end

  // Inputs settle at posedge+1, so negedge shows the handshakes of the next edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int p = 0; p < NB; p++) begin
        if (mst_ar_valid[p] && mst_ar_ready[p]) begin
          if (ar_exp.size() == 0) chk("ar_unexpected_port", p, -1);
          else                    chk("ar_order", p, ar_exp.pop_front());
        end
        if (mst_aw_valid[p] && mst_aw_ready[p]) begin
          if (aw_exp.size() == 0) chk("aw_unexpected_port", p, -1);
          else                    chk("aw_order", p, aw_exp.pop_front());
        end
      end
    end
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b1;
    mst_aw_ready = '0; mst_ar_ready = '0;
    b_valid = '0; b_ready = '0; r_valid = '0; r_ready = '0; r_last = '0;
    step(3);
    chk("rst_mst_ar_valid", int'(mst_ar_valid), 0);
    chk("rst_mst_aw_valid", int'(mst_aw_valid), 0);
    chk("rst_slv_ar_ready", int'(slv_ar_ready), 0);
    chk("rst_rd_outstnd", int'(rd_outstnd), 0);
    chk("rst_wr_total", int'(wr_total), 0);
    chk("rst_underflow", int'(underflow), 0);
    rst_ni = 1'b1;

    // single AR on port 0
    mst_ar_ready = '1; mst_aw_ready = '1;
    ar_issued[0] += 1; ar_exp.push_back(0);
    step(1);
    chk("t1_mst_valid", int'(mst_ar_valid[0]), 1);
    chk("t1_rd_cnt0", int'(rd_c[0]), 1);
    chk("t1_rd_total", int'(rd_total), 1);
    step(1);
    chk("t1_valid_drop", int'(mst_ar_valid[0]), 0);
    r_valid[0] = 1'b1; r_ready[0] = 1'b1; r_last[0] = 1'b1;
    step(1);
    r_valid = '0; r_ready = '0; r_last = '0;
    chk("t1_rd_cnt0_ret", int'(rd_c[0]), 0);
    chk("t1_rd_total_ret", int'(rd_total), 0);

    // port 2: 9 AWs against a per-port limit of 8
    aw_issued[2] += 9;
    for (int k = 0; k < 8; k++) aw_exp.push_back(2);
    step(20);
    chk("t2_wr_cnt2", int'(wr_c[2]), 8);
    chk("t2_wr_total", int'(wr_total), 8);
    chk("t2_slv_ready_held", int'(slv_aw_ready[2]), 0);
    chk("t2_mst_valid_held", int'(mst_aw_valid[2]), 0);
    aw_exp.push_back(2);
    b_valid[2] = 1'b1; b_ready[2] = 1'b1;
    step(1);
    b_valid = '0; b_ready = '0;
    chk("t2_cnt_after_b", int'(wr_c[2]), 7);
    chk("t2_no_early_grant", int'(mst_aw_valid[2]), 0);
    step(1);
    chk("t2_grant_after_b", int'(mst_aw_valid[2]), 1);
    chk("t2_cnt_regrant", int'(wr_c[2]), 8);
    step(1);
    b_valid[2] = 1'b1; b_ready[2] = 1'b1;
    step(8);
    b_valid = '0; b_ready = '0;
    chk("t2_wr_drained", int'(wr_total), 0);

    // all ports request AR, global read budget of 12
    do_reset();
    for (int p = 0; p < NB; p++) ar_issued[p] += 4;
    for (int k = 0; k < 12; k++) ar_exp.push_back(k % NB);
    step(30);
    chk("t3_rd_total", int'(rd_total), 12);
    for (int p = 0; p < NB; p++) chk("t3_rd_cnt", int'(rd_c[p]), 3);
    chk("t3_mst_valid", int'(mst_ar_valid), 0);
    chk("t3_slv_ready", int'(slv_ar_ready), 0);
    chk("t3_ar_queue", ar_exp.size(), 0);

    // grant and last-R on port 1 in the same cycle
    do_reset();
    ar_issued[1] += 5;
    for (int k = 0; k < 5; k++) ar_exp.push_back(1);
    step(12);
    chk("t4_pre_cnt1", int'(rd_c[1]), 5);
    ar_issued[1] += 1; ar_exp.push_back(1);
    r_valid[1] = 1'b1; r_ready[1] = 1'b1; r_last[1] = 1'b1;
    step(1);
    r_valid = '0; r_ready = '0; r_last = '0;
    chk("t4_granted", int'(mst_ar_valid[1]), 1);
    chk("t4_cnt1_net", int'(rd_c[1]), 5);
    chk("t4_total_net", int'(rd_total), 5);
    step(1);

    // limits disabled, then re-enabled with port 0 over its limit
    do_reset();
    en_i = 1'b0;
    ar_issued[0] += 10;
    for (int k = 0; k < 10; k++) ar_exp.push_back(0);
    step(24);
    chk("t5_cnt0_unlimited", int'(rd_c[0]), 10);
    chk("t5_total_unlimited", int'(rd_total), 10);
    mst_ar_ready[0] = 1'b0;
    ar_issued[0] += 1; ar_exp.push_back(0);
    step(1);
    chk("t5_fwd_granted", int'(mst_ar_valid[0]), 1);
    en_i = 1'b1;
    step(3);
    chk("t5_fwd_held", int'(mst_ar_valid[0]), 1);
    chk("t5_cnt0_held", int'(rd_c[0]), 11);
    mst_ar_ready[0] = 1'b1;
    step(1);
    chk("t5_fwd_released", int'(mst_ar_valid[0]), 0);
    ar_issued[0] += 1; ar_exp.push_back(0);
    r_valid[0] = 1'b1; r_ready[0] = 1'b1; r_last[0] = 1'b1;
    step(3);
    r_valid = '0; r_ready = '0; r_last = '0;
    chk("t5_cnt0_at_limit", int'(rd_c[0]), 8);
    chk("t5_blocked_at_limit", int'(mst_ar_valid[0]), 0);
    r_valid[0] = 1'b1; r_ready[0] = 1'b1; r_last[0] = 1'b1;
    step(1);
    r_valid = '0; r_ready = '0; r_last = '0;
    chk("t5_cnt0_below", int'(rd_c[0]), 7);
    chk("t5_no_same_cycle_grant", int'(mst_ar_valid[0]), 0);
    step(1);
    chk("t5_regrant", int'(mst_ar_valid[0]), 1);
    chk("t5_cnt0_regrant", int'(rd_c[0]), 8);
    step(1);

    // B with zero outstanding writes, then a mid-transaction reset
    do_reset();
    b_valid[3] = 1'b1; b_ready[3] = 1'b1;
    step(1);
    b_valid = '0; b_ready = '0;
    chk("t6_wr_cnt3", int'(wr_c[3]), 0);
    chk("t6_wr_total", int'(wr_total), 0);
    chk("t6_underflow", int'(underflow), 1);
    step(2);
    chk("t6_underflow_sticky", int'(underflow), 1);
    mst_ar_ready = '0;
    ar_issued[1] += 1;
    step(1);
    chk("t6_pre_rst_valid", int'(mst_ar_valid[1]), 1);
    chk("t6_pre_rst_total", int'(rd_total), 1);
    do_reset();
    chk("t6_rst_mst_valid", int'(mst_ar_valid), 0);
    chk("t6_rst_slv_ready", int'(slv_ar_ready), 0);
    chk("t6_rst_rd_outstnd", int'(rd_outstnd), 0);
    chk("t6_rst_rd_total", int'(rd_total), 0);
    chk("t6_rst_underflow", int'(underflow), 0);
    step(2);
    chk("end_ar_queue", ar_exp.size(), 0);
    chk("end_aw_queue", aw_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cluster_bus_txn_regulator.md
Name: cluster_bus_txn_regulator

Overview:
- Per-port admission controller placed between the cluster AXI initiators (data, instr, DMA, ext) and the cluster crossbar slave ports.
- Gates AW and AR valids so each port stays within a per-port outstanding-transaction limit, and all ports together stay within a read budget and a write budget sized to the crossbar's transaction tables.
- Arbitrates the shared budgets round-robin. Tracks retirements by observing B and last-R handshakes.
- Payload buses are not routed through the block; only the valid/ready pairs are.

Parameters:
- NB_PORTS, 4, number of regulated slave ports.
- MAX_PORT_TXNS, 8, max outstanding reads (and, separately, writes) per port; must be ≥1.
- MAX_RD_TOTAL, 12, max outstanding reads summed over all ports.
- MAX_WR_TOTAL, 12, max outstanding writes summed over all ports.
- CNT_W, $clog2(max(MAX_PORT_TXNS, MAX_RD_TOTAL, MAX_WR_TOTAL)+1), counter width (derived, not overridden).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- en_i  in  1  1 = enforce limits; 0 = grant whenever valid (counting continues)
- slv_aw_valid_i  in  NB_PORTS  AW valid from initiator
- slv_aw_ready_o  out  NB_PORTS  AW ready to initiator
- mst_aw_valid_o  out  NB_PORTS  AW valid to crossbar
- mst_aw_ready_i  in  NB_PORTS  AW ready from crossbar
- slv_ar_valid_i / slv_ar_ready_o / mst_ar_valid_o / mst_ar_ready_i  as AW, read channel
- b_valid_i, b_ready_i  in  NB_PORTS  observed B handshake per port
- r_valid_i, r_ready_i, r_last_i  in  NB_PORTS  observed R handshake per port
- rd_outstnd_o  out  NB_PORTS*CNT_W  per-port outstanding reads
- wr_outstnd_o  out  NB_PORTS*CNT_W  per-port outstanding writes
- rd_total_o, wr_total_o  out  CNT_W  summed outstanding counts
- underflow_o  out  1  sticky: retirement seen while that port's count was 0

Behaviour:
- Two identical independent engines: AW engine (write counters) and AR engine (read counters).
- Each port in each engine has a 2-state FSM: IDLE, FWD.
  - IDLE→FWD on grant.
  - FWD→IDLE on mst_ready_i & mst_valid_o.
- mst_*_valid_o = (state==FWD). It is registered and never depends on any ready input.
- slv_*_ready_o = (state==FWD) & mst_*_ready_i, combinational.
- Latency: slave valid in cycle N → earliest mst valid in cycle N+1. Back-to-back AX from one port: one bubble cycle minimum (FWD→IDLE→FWD).
- Grant, evaluated each cycle:
  - At most one new grant per engine per cycle.
  - Eligible port: IDLE & slv_valid & (en_i=0 or (port_cnt < MAX_PORT_TXNS and total < MAX_*_TOTAL)).
  - Among eligible ports, pick round-robin from the priority pointer. After a grant, the pointer = granted index+1, mod NB_PORTS. With no grant the pointer holds.
- Counting:
  - Credit is reserved at grant: port_cnt and total increment on the grant cycle, not on the handshake.
  - Write decrement: b_valid_i & b_ready_i. Read decrement: r_valid_i & r_ready_i & r_last_i.
  - Grant and retire on the same port in the same cycle → net unchanged. Same for total, summed over all events that cycle.
  - Increment saturates at 2^CNT_W-1; this is only reachable with en_i=0.
  - Decrement at 0 keeps 0 and sets underflow_o. underflow_o clears only on reset.
- en_i toggling:
  - Takes effect on the next grant decision.
  - A port already in FWD keeps valid asserted until its handshake (AXI valid stability).
  - Counts above a limit after re-enabling just block new grants until they drain.
- Reset (rst_ni=0 at a clock edge): all FSMs IDLE, counters 0, pointers 0, underflow_o=0. Hence all mst valids=0, all slv readies=0, all counts=0.
  - Reset mid-transaction drops in-flight tracking. The integrator must reset the crossbar and initiators together with this block.
- A slave valid deasserted before its handshake is a protocol violation; the block need not handle it. Assertions in the bench flag it.

Test Plan:
- Single AR on port 0, crossbar ready=1 → mst_ar_valid_o[0] rises 1 cycle after the request, handshake next cycle, rd_outstnd[0]=1, rd_total=1; R last handshake → both return to 0.
- Port 2 issues 9 AWs, no B, MAX_PORT_TXNS=8 → 8 accepted; 9th held (slv_aw_ready_o[2]=0) until a B on port 2, then granted 1 cycle later.
- All 4 ports continuously request AR, no R returns, MAX_RD_TOTAL=12 → grant order 0,1,2,3,0,… stops at rd_total=12, each port at 3.
- Grant and last-R on port 1 in the same cycle with rd_outstnd[1]=5 → stays 5; rd_total unchanged.
- en_i=0 with 10 outstanding reads on port 0 → grants continue to 10; en_i=1 → no port-0 grant until count <8; a FWD port held across the toggle keeps valid until ready.
- B handshake on port 3 with wr_outstnd[3]=0 → count stays 0, underflow_o=1 and sticky; rst_ni=0 for one cycle → all outputs return to reset values.
